// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port OTTER memory: data beats fetch,
// address/size/sign held through the registered BRAM read. `ARB_ROUND_ROBIN_EN` selects alternating priority.
module mem_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  input  logic [1:0]           d_size,
  input  logic                 d_sign,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_err,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sign,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 mem_error,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_d_q;   // 1 = data requester owns the in-flight access
  logic   lat_we_q;
  logic   d_win, if_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_d_q;      // 1 = data wins a tie

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_d_q <= 1'b1;
    else if (d_gnt)  prio_d_q <= 1'b0;
    else if (if_gnt) prio_d_q <= 1'b1;
  end

  assign d_win  = d_req  & (~if_req | prio_d_q);
  assign if_win = if_req & (~d_req  | ~prio_d_q);
`else
  assign d_win  = d_req;
  assign if_win = if_req & ~d_req;
`endif

  // Handshake: a requester holds req (and payload) until gnt; gnt is high for one
  // IDLE cycle, and the response arrives later as a single-cycle valid strobe.
  assign d_gnt  = (state_q == IDLE) & d_win;
  assign if_gnt = (state_q == IDLE) & if_win;
  assign busy   = (state_q != IDLE);
  assign mem_we = lat_we_q & (state_q == ACCESS) & ~mem_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_gnt | if_gnt) state_d = ACCESS;
      ACCESS:  state_d = (lat_we_q | mem_error) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d_q <= 1'b0;
      lat_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_size  <= 2'b10;
      mem_sign  <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_gnt) begin
            owner_d_q <= 1'b1;
            lat_we_q  <= d_we;
            mem_addr  <= d_addr;
            mem_data  <= d_wdata;
            mem_size  <= d_size;
            mem_sign  <= d_sign;
          end else if (if_gnt) begin
            owner_d_q <= 1'b0;
            lat_we_q  <= 1'b0;
            mem_addr  <= if_addr;
            mem_data  <= '0;
            mem_size  <= 2'b10;
            mem_sign  <= 1'b1;
          end
        end
        ACCESS: begin
          // Stores and faulting accesses finish here with no read data.
          if (lat_we_q | mem_error) begin
            if (owner_d_q) begin
              d_valid <= 1'b1;
              d_rdata <= '0;
              d_err   <= mem_error;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= '0;
              if_err   <= mem_error;
            end
          end
        end
        RESP: begin
          if (owner_d_q) begin
            d_valid <= 1'b1;
            d_rdata <= mem_rdata;
            d_err   <= 1'b0;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
            if_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural BRAM (registered read, combinational splice/error).
module tb_mem_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_gnt, if_valid, if_err;
  logic [W-1:0] if_rdata;
  logic         d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic [1:0]   d_size = 2'b10;
  logic         d_gnt, d_valid, d_err;
  logic [W-1:0] d_rdata;
  logic         mem_we, mem_sign, mem_error, busy;
  logic [W-1:0] mem_addr, mem_data, mem_rdata;
  logic [1:0]   mem_size;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_arbiter #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_sign(mem_sign), .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy)
  );

  // memory model
  logic [W-1:0] ram [0:1023];
  logic [W-1:0] rd_word_q;
  bit           loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
      ram[4] <= 32'h00C0FFEE;
      loaded <= 1'b1;
    end else if (mem_we) begin
      case (mem_size)
        2'b00:   ram[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_data[7:0];
        2'b01:   ram[mem_addr[11:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_data[15:0];
        default: ram[mem_addr[11:2]] <= mem_data;
      endcase
    end
    rd_word_q <= ram[mem_addr[11:2]];
  end

  function automatic logic [W-1:0] splice(input logic [W-1:0] w, input logic [W-1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [W-1:0] sh;
    sh = w >> {a[1:0], 3'b000};
    case (sz)
      2'b00:   return sg ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return sg ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  assign mem_rdata = splice(rd_word_q, mem_addr, mem_size, mem_sign);
  assign mem_error = (mem_size == 2'b11) || (mem_size == 2'b01 && mem_addr[0]) ||
                     (mem_size == 2'b10 && mem_addr[1:0] != 2'b00) || (mem_addr >= 32'h1000);

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one full transaction with cycle-exact latency checks
  task automatic issue(input string tag, input bit is_d, input bit we, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata, input logic [1:0] size, input bit sign,
                       input bit exp_err, input logic [W-1:0] exp_rd);
    int  t;
    bit  short_path;
    logic [W-1:0] exp;
    exp_q.push_back(exp_rd);
    short_path = we | exp_err;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    t = 0;
    while (!(is_d ? d_gnt : if_gnt) && t < 10) begin
      @(negedge clk); #1; t++;
    end
    check_val({tag, "_gnt"}, {31'b0, (is_d ? d_gnt : if_gnt)}, 32'd1);
    check_val({tag, "_other_gnt"}, {31'b0, (is_d ? if_gnt : d_gnt)}, 32'd0);
    @(negedge clk);                       // N+1: ACCESS
    d_req = 1'b0; if_req = 1'b0;
    check_val({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check_val({tag, "_addr1"}, mem_addr, addr);
    check_val({tag, "_we1"}, {31'b0, mem_we}, {31'b0, we & ~exp_err});
    if (!short_path) begin
      @(negedge clk);                     // N+2: RESP
      check_val({tag, "_addr2"}, mem_addr, addr);
      check_val({tag, "_we2"}, {31'b0, mem_we}, 32'd0);
      check_val({tag, "_early"}, {31'b0, (is_d ? d_valid : if_valid)}, 32'd0);
    end
    @(negedge clk);                       // response cycle
    exp = exp_q.pop_front();
    check_val({tag, "_valid"}, {31'b0, (is_d ? d_valid : if_valid)}, 32'd1);
    check_val({tag, "_other_valid"}, {31'b0, (is_d ? if_valid : d_valid)}, 32'd0);
    check_val({tag, "_rdata"}, (is_d ? d_rdata : if_rdata), exp);
    check_val({tag, "_err"}, {31'b0, (is_d ? d_err : if_err)}, {31'b0, exp_err});
    check_val({tag, "_we_idle"}, {31'b0, mem_we}, 32'd0);
  endtask

  int n_d, n_if, n_both, t;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_we", {31'b0, mem_we}, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    check_val("rst_size", {30'b0, mem_size}, 32'd2);
    check_val("rst_sign", {31'b0, mem_sign}, 32'd0);
    check_val("rst_valid", {30'b0, if_valid, d_valid}, 32'd0);
    check_val("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;

    issue("fetch10",  0, 0, 32'h10,   '0,           2'b10, 1, 0, 32'h00C0FFEE);
    issue("st10",     1, 1, 32'h10,   32'h80000000, 2'b10, 0, 0, 32'h0);
    issue("lb13",     1, 0, 32'h13,   '0,           2'b00, 0, 0, 32'hFFFFFF80);
    @(negedge clk);
    check_val("lb13_hold_valid", {31'b0, d_valid}, 32'd0);
    check_val("lb13_hold_rdata", d_rdata, 32'hFFFFFF80);
    issue("lbu13",    1, 0, 32'h13,   '0,           2'b00, 1, 0, 32'h00000080);
    issue("lh12",     1, 0, 32'h12,   '0,           2'b01, 0, 0, 32'hFFFF8000);
    issue("st20",     1, 1, 32'h20,   32'hDEADBEEF, 2'b10, 0, 0, 32'h0);
    issue("lw20",     1, 0, 32'h20,   '0,           2'b10, 0, 0, 32'hDEADBEEF);
    issue("st22_mis", 1, 1, 32'h22,   32'h12345678, 2'b10, 0, 1, 32'h0);
    issue("lw20_again", 1, 0, 32'h20, '0,           2'b10, 0, 0, 32'hDEADBEEF);
    issue("lh11_mis", 1, 0, 32'h11,   '0,           2'b01, 0, 1, 32'h0);
    issue("fetch_oor", 0, 0, 32'h2000, '0,          2'b10, 1, 1, 32'h0);

    // contention: both requesters hold req for 12 cycles, data side issues stores
    n_d = 0; n_if = 0; n_both = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5A5A5A5A; d_size = 2'b10;
    if_req = 1'b1; if_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (d_gnt) n_d++;
      if (if_gnt) n_if++;
      if (d_gnt && if_gnt) n_both++;
    end
    d_req = 1'b0; if_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    check_val("cont_d_gnts", n_d, 32'd3);
    check_val("cont_if_gnts", n_if, 32'd2);
`else
    check_val("cont_d_gnts", n_d, 32'd6);
    check_val("cont_if_gnts", n_if, 32'd0);
`endif
    check_val("cont_both", n_both, 32'd0);
    t = 0;
    while (busy && t < 10) begin
      @(negedge clk); t++;
    end
    check_val("cont_drain", {31'b0, busy}, 32'd0);

    // reset abort during RESP of a fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1 check_val("abort_gnt", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    check_val("abort_busy_resp", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_if = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_valid) n_if++;
    end
    check_val("abort_no_valid", n_if, 32'd0);

    // reset abort during store ACCESS: write must never land
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hAAAA5555; d_size = 2'b10; d_sign = 1'b0;
    #1 check_val("stabort_gnt", {31'b0, d_gnt}, 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    check_val("stabort_we_on", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1 check_val("stabort_we_off", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("lw30_unwritten", 1, 0, 32'h30, '0, 2'b10, 0, 0, 32'h0);
    issue("fetch_after", 0, 0, 32'h10, '0, 2'b10, 1, 0, 32'h80000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port OTTER data/instruction memory.
- Requesters: instruction fetch (if_*) and load/store unit (d_*).
- Serialises requests onto the memory port and holds address/size/sign stable through the BRAM's 1-cycle registered read, because the memory's output splice decodes those inputs combinationally.
- Returns a registered response (data + error) to the granted requester.

Parameters:
- BUS_WIDTH, 32, width of address and data buses.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  BUS_WIDTH  fetch address, always WORD/unsigned
- if_gnt  output  1  fetch request accepted this cycle
- if_valid  output  1  one-cycle fetch response strobe
- if_rdata  output  BUS_WIDTH  fetched word
- if_err  output  1  fetch access error, qualified by if_valid
- d_req  input  1  data request; held with payload until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  BUS_WIDTH  data address
- d_wdata  input  BUS_WIDTH  store data
- d_size  input  2  00 byte, 01 half, 10 word
- d_sign  input  1  0 signed, 1 unsigned
- d_gnt  output  1  data request accepted this cycle
- d_valid  output  1  one-cycle data response strobe
- d_rdata  output  BUS_WIDTH  load result; 0 for stores
- d_err  output  1  data access error, qualified by d_valid
- mem_we  output  1  memory write enable
- mem_addr  output  BUS_WIDTH  memory address
- mem_data  output  BUS_WIDTH  memory write data
- mem_size  output  2  memory access size
- mem_sign  output  1  memory sign select
- mem_rdata  input  BUS_WIDTH  memory read data, spliced
- mem_error  input  1  memory combinational address/alignment error
- busy  output  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; owner = fetch.
  - mem_we, mem_addr, mem_data, mem_sign = 0; mem_size = 2'b10.
  - All gnt/valid/err outputs = 0; all rdata outputs = 0; busy = 0.
- States:
  - IDLE: accepts a request.
  - ACCESS: drives the latched request; BRAM write or read issued.
  - RESP: reads only; holds address, captures spliced data.
- Arbitration (IDLE only):
  - Fixed priority: d_req beats if_req.
  - gnt is combinational: IDLE & req & winner. It is high for exactly one cycle.
  - On the gnt edge, latch addr/size/sign/we/wdata and owner, then go to ACCESS.
  - Fetch latches size = 10, sign = 1, we = 0.
- mem_* outputs:
  - mem_addr/size/sign/data are driven from the latch registers only. They are stable from ACCESS through RESP, and hold their last value in IDLE.
  - mem_we = latched_we & (state == ACCESS) & ~mem_error. A misaligned or out-of-range store never writes.
- ACCESS state:
  - Sample mem_error into err_q.
  - If a store, or if mem_error: go to IDLE and pulse the owner's valid next cycle. rdata = 0, err = err_q.
  - Otherwise go to RESP.
- RESP state:
  - Register mem_rdata into owner's rdata; err = 0.
  - Go to IDLE with the owner's valid pulsed next cycle.
- Latency, with gnt at cycle N:
  - Store or error: valid at N+2.
  - Load or fetch: valid at N+3.
- Back-to-back: a new gnt may occur in the same cycle a valid is pulsed (state IDLE). Throughput is 1 access per 2 cycles for stores and 3 cycles for reads.
- valid and rdata registers:
  - Non-owner valid stays 0.
  - rdata/err hold their values after valid drops, until the next response for that requester.
- Request withdrawn before gnt: ignored, no side effect. Requests while busy: no gnt; the requester keeps holding.
- Reset mid-operation: immediate return to IDLE; mem_we drops asynchronously; the in-flight response is discarded with no valid pulse.
- Simultaneous d_req and if_req in IDLE: d_gnt = 1, if_gnt = 0. Fetch is granted at the next IDLE if still requested.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the priority pointer toggles after each grant, and the requester not most recently granted wins a simultaneous request. Reset pointer favours data. A lone request is always granted.
- Undefined: fixed data-over-fetch priority as above; no pointer register.

Test Plan:
- Fetch read: if_req, if_addr = 0x10, memory word 0x00C0FFEE. Required: if_gnt at N, mem_addr = 0x10 stable for N+1..N+2, mem_we = 0, if_valid at N+3 with if_rdata = 0x00C0FFEE and if_err = 0.
- Signed byte load: d_addr = 0x13, size = 00, sign = 0, word 0x80000000. Required: d_valid at N+3, d_rdata = 0xFFFFFF80.
- Aligned store: d_we = 1, d_addr = 0x20, size = 10, d_wdata = 0xDEADBEEF. Required: mem_we = 1 only in cycle N+1, d_valid at N+2 with d_rdata = 0. A following load from 0x20 returns 0xDEADBEEF.
- Misaligned store: d_we = 1, d_addr = 0x22, size = 10. Required: mem_we stays 0, d_valid at N+2 with d_err = 1, and memory is unchanged.
- Contention: if_req and d_req both asserted continuously. Fixed priority: d_gnt on every IDLE and if_gnt never. With ARB_ROUND_ROBIN_EN: grants alternate d, if, d, if.
- Reset abort: rst_n low in RESP of a fetch. Required: busy = 0 and mem_we = 0 immediately, no if_valid afterwards, and the next request completes normally.
